// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard register.
// Imported by ps2_rx and ps2_keyboard_reg.
package ps2_kbd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam int KBD_VALID_BIT = 8;
    localparam int KBD_BREAK_BIT = 9;
    localparam int KBD_EXT_BIT   = 10;
    localparam int KBD_OVF_BIT   = 11;
    localparam int KBD_PERR_BIT  = 12;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef struct packed {
        logic       perr;
        logic       ovf;
        logic       ext;
        logic       brk;
        logic       valid;
        logic [7:0] code;
    } kbd_reg_t;

    // Odd parity holds when data bits plus parity bit have an odd count of ones.
    function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronisers, falling-edge
// detect, frame FSM and inactivity timeout.
module ps2_rx
    import ps2_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       perr_pulse
);

    localparam int            TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          fall;
    logic          din;
    logic          timeout;
    logic          stop_fall;
    logic          good;
    ps2_state_t    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity;
    logic [TW-1:0] tcnt;

    // Two-stage synchronisers plus a third clock stage for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign fall    = clk_sync[2] & ~clk_sync[1];
    assign din     = data_sync[1];
    assign timeout = (state != IDLE) && (tcnt == TLAST);

    // Inactivity counter, restarted by every PS/2 clock fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
        end else if (fall || state == IDLE) begin
            tcnt <= '0;
        end else if (tcnt != TLAST) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // Frame FSM: start bit, eight data bits LSB first, parity, stop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            parity  <= 1'b0;
        end else if (fall) begin
            unique case (state)
                IDLE: begin
                    if (!din) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    shreg   <= {din, shreg[7:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state <= PARITY;
                    end
                end
                PARITY: begin
                    parity <= din;
                    state  <= STOP;
                end
                STOP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end else if (timeout) begin
            state <= IDLE;
        end
    end

    // Byte verdict is issued in the same cycle the stop-bit fall is seen,
    // so the top-level register updates on the following edge.
    assign stop_fall  = fall && (state == STOP);
    assign good       = din && odd_parity_ok(shreg, parity);
    assign byte_done  = stop_fall && good;
    assign perr_pulse = stop_fall && !good;
    assign rx_byte    = shreg;

endmodule

// File: rtl/ps2_keyboard_reg.sv
// Memory-mapped PS/2 keyboard status/data register with prefix folding
// and clear-on-read.
module ps2_keyboard_reg
    import ps2_kbd_pkg::*;
#(
    parameter int          N              = 32,
    parameter logic [16:0] KBD_ADDR       = 17'h100,
    parameter int          TIMEOUT_CYCLES = 50000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    input  logic [16:0]  address,
    input  logic         rd_en,
    output logic [N-1:0] rdKeyboard
);

    logic [7:0] rx_byte;
    logic       byte_done;
    logic       perr_pulse;
    logic       rd_hit;
    logic       is_ext;
    logic       is_brk;
    logic       post;
    logic       ext_pend;
    logic       brk_pend;
    kbd_reg_t   kreg;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .byte_done (byte_done),
        .perr_pulse(perr_pulse)
    );

    assign rd_hit = rd_en && (address == KBD_ADDR);
    assign is_ext = byte_done && (rx_byte == PS2_EXT);
    assign is_brk = byte_done && (rx_byte == PS2_BRK);
    assign post   = byte_done && !is_ext && !is_brk;

    // Prefix flags collect E0/F0 until the next non-prefix byte consumes them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (post) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else begin
            if (is_ext) ext_pend <= 1'b1;
            if (is_brk) brk_pend <= 1'b1;
        end
    end

    // Event register: a new key wins over a simultaneous read; a read
    // consumes valid/ovf/perr but keeps the last code visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kreg <= '0;
        end else begin
            if (post) begin
                kreg.code  <= rx_byte;
                kreg.valid <= 1'b1;
                kreg.brk   <= brk_pend;
                kreg.ext   <= ext_pend;
                kreg.ovf   <= rd_hit ? 1'b0 : (kreg.ovf | kreg.valid);
            end else if (rd_hit) begin
                kreg.valid <= 1'b0;
                kreg.ovf   <= 1'b0;
            end
            if (perr_pulse) begin
                kreg.perr <= 1'b1;
            end else if (rd_hit) begin
                kreg.perr <= 1'b0;
            end
        end
    end

    // Read word is combinational so a load returns the pre-clear value.
    always_comb begin
        rdKeyboard                = '0;
        rdKeyboard[7:0]           = kreg.code;
        rdKeyboard[KBD_VALID_BIT] = kreg.valid;
        rdKeyboard[KBD_BREAK_BIT] = kreg.brk;
        rdKeyboard[KBD_EXT_BIT]   = kreg.ext;
        rdKeyboard[KBD_OVF_BIT]   = kreg.ovf;
        rdKeyboard[KBD_PERR_BIT]  = kreg.perr;
    end

endmodule

// File: tb/tb_ps2_keyboard_reg.sv
// Scoreboard bench for ps2_keyboard_reg: event-level key model,
// expected read words queued at load time and checked by a bus monitor.
module tb_ps2_keyboard_reg;

    localparam int          TOUT = 300;
    localparam int          HALF = 8;
    localparam logic [16:0] KA   = 17'h100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [16:0] address = '0;
    logic        rd_en = 1'b0;
    logic [31:0] rdKeyboard;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];

    // event-level model of the keyboard register
    logic [7:0] m_code;
    bit m_valid, m_brk, m_ext, m_ovf, m_perr, m_extp, m_brkp;

    ps2_keyboard_reg #(
        .N(32),
        .KBD_ADDR(KA),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .address   (address),
        .rd_en     (rd_en),
        .rdKeyboard(rdKeyboard)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_word();
        return {19'd0, m_perr, m_ovf, m_ext, m_brk, m_valid, m_code};
    endfunction

    task automatic model_reset();
        m_code = '0;
        m_valid = 0; m_brk = 0; m_ext = 0;
        m_ovf = 0; m_perr = 0; m_extp = 0; m_brkp = 0;
    endtask

    task automatic model_read();
        m_valid = 0;
        m_ovf = 0;
        m_perr = 0;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit good);
        if (!good) begin
            m_perr = 1;
        end else if (b == 8'hE0) begin
            m_extp = 1;
        end else if (b == 8'hF0) begin
            m_brkp = 1;
        end else begin
            m_ovf = m_ovf | m_valid;
            m_valid = 1;
            m_code = b;
            m_brk = m_brkp;
            m_ext = m_extp;
            m_extp = 0;
            m_brkp = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive nbits of a frame; optionally load the register in the cycle
    // where the stop-bit fall is detected (2 clk after the pin edge).
    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input bit bad_stop, input int nbits,
                              input bit rd_at_stop);
        logic [10:0] fr;
        fr[0] = 1'b0;
        fr[8:1] = b;
        fr[9] = ~(^b) ^ bad_par;
        fr[10] = ~bad_stop;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            wait_clk(HALF);
            ps2_clk = 1'b0;
            if (rd_at_stop && i == 10) begin
                wait_clk(2);
                exp_q.push_back(exp_word());
                model_read();
                rd_en = 1'b1;
                address = KA;
                wait_clk(1);
                rd_en = 1'b0;
                wait_clk(HALF - 3);
            end else begin
                wait_clk(HALF);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_clk(2);
    endtask

    task automatic key(input logic [7:0] b);
        send_frame(b, 0, 0, 11, 0);
        model_frame(b, 1);
    endtask

    task automatic load(input logic [16:0] a);
        rd_en = 1'b1;
        address = a;
        if (a == KA) begin
            exp_q.push_back(exp_word());
            model_read();
        end
        wait_clk(1);
        rd_en = 1'b0;
        address = '0;
        wait_clk(1);
    endtask

    // Bus monitor: every load of the keyboard address is scored.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset && rd_en && address == KA) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected: got %h expected none", rdKeyboard);
            end else begin
                e = exp_q.pop_front();
                check("rd_word", rdKeyboard, e);
            end
        end
    end

    initial begin
        logic [7:0] b;
        int r;
        bit bp, bs;
        model_reset();
        wait_clk(3);
        check("reset_state", rdKeyboard, 32'h0);
        reset = 1'b0;
        wait_clk(3);

        key(8'h1C);
        load(KA);
        load(KA);

        key(8'hF0); key(8'h1C); load(KA);
        key(8'hE0); key(8'h75); load(KA);
        key(8'hE0); key(8'hF0); key(8'h75); load(KA);
        key(8'hE0); load(KA);
        key(8'hF0); load(KA);
        key(8'h1C); load(KA);

        send_frame(8'h1C, 1, 0, 11, 0);
        model_frame(8'h1C, 0);
        check("perr_set", rdKeyboard, exp_word());
        load(KA);
        load(KA);

        send_frame(8'h55, 0, 0, 5, 0);
        wait_clk(TOUT + 20);
        check("timeout_quiet", rdKeyboard, exp_word());
        key(8'h2A);
        load(KA);

        key(8'h1C); key(8'h32);
        load(KA);
        load(KA);

        key(8'h1C);
        send_frame(8'h32, 0, 0, 11, 1);
        model_frame(8'h32, 1);
        check("collide_new", rdKeyboard, exp_word());
        load(17'h104);
        check("other_addr", rdKeyboard, exp_word());
        load(KA);
        send_frame(8'h44, 1, 0, 11, 1);
        model_frame(8'h44, 0);
        check("collide_perr", rdKeyboard, exp_word());
        load(KA);

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 99);
            b = 8'($urandom_range(0, 255));
            if (r < 12) b = 8'hE0;
            else if (r < 24) b = 8'hF0;
            bp = ($urandom_range(0, 9) == 0);
            bs = ($urandom_range(0, 19) == 0);
            r = $urandom_range(0, 5);
            if (r < 2) begin
                send_frame(b, bp, bs, 11, 0);
                model_frame(b, !bp && !bs);
            end else if (r == 2) begin
                send_frame(b, bp, bs, 11, 1);
                model_frame(b, !bp && !bs);
            end else if (r == 3) begin
                load(17'h104);
            end else begin
                load(KA);
            end
        end
        load(KA);

        key(8'h5A);
        send_frame(8'h1C, 0, 0, 5, 0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check("async_reset", rdKeyboard, 32'h0);
        model_reset();
        wait_clk(2);
        reset = 1'b0;
        wait_clk(2);
        key(8'h1C);
        load(KA);

        wait_clk(2);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
